fifo_drain_arb: RTL and testbench
=================================

// Module: fifo_drain_arb
// PURPOSE
//  Reader side of the valid-yumi FIFO output protocol. Drains num_src_p FIFO output
//  ports round-robin into one 2-entry skid buffer, presented downstream as valid-ready
//  with the source index. Used where several OoO queues (e.g. FU result FIFOs) share
//  one consumer such as the CDB/ROB write port.
// PARAMETERS
//  DTYPE           logic[7:0]              payload type, matches upstream FIFO DTYPE
//  num_src_p       2                       number of valid-yumi sources, 2..8
//  src_idx_width_p $clog2(num_src_p)       width of src_o; must be >= 1
// PORTS
//  clk_i        in   1                     clock
//  reset_n_i    in   1                     reset, asynchronous, active-low
//  flush_i      in   1                     sync flush: drop buffered entries, grant nothing
//  src_valid_i  in   num_src_p             per-source valid (upstream valid_o)
//  src_data_i   in   num_src_p x DTYPE     per-source head data (upstream data_o)
//  src_yumi_o   out  num_src_p             per-source yumi (one-hot or zero)
//  valid_o      out  1                     downstream valid
//  data_o       out  DTYPE                 downstream data
//  src_o        out  src_idx_width_p       source index of data_o
//  ready_i      in   1                     downstream ready
// BEHAVIOUR
//  - State: 2-entry buffer (data+src), head ptr, count 0..2, round-robin ptr rr 0..N-1.
//  - Reset (async, reset_n_i=0): count=0, head=0, rr=0; valid_o=0; src_yumi_o=0 (gated
//    by reset_n_i). data_o/src_o are don't-care while valid_o=0.
//  - Grant (combinational): if count<2 or (count==2 is never granted), and !flush_i,
//    select first i with src_valid_i[i]=1 scanning rr, rr+1, ... wrapping mod num_src_p.
//    src_yumi_o[i]=1 only for that i. src_yumi_o[i] never high when src_valid_i[i]=0.
//  - Grant when count==1 & dequeue same cycle is allowed; count==2 never grants, even
//    if ready_i=1 that cycle (keeps yumi off the ready_i path).
//  - On grant to i at posedge: write {src_data_i[i], i} at tail=(head+count) mod 2;
//    rr <= (i+1) mod num_src_p. No grant -> rr holds.
//  - Output: valid_o = (count!=0); data_o/src_o = entry[head]; registered, no comb
//    path from src_* to data_o. Dequeue = valid_o & ready_i: head <= head^1.
//  - count' = count + grant - dequeue. Simultaneous grant+dequeue keeps count.
//  - Throughput 1 item/cycle steady state; latency grant->valid_o = 1 cycle.
//  - Stall: while valid_o & !ready_i, data_o/src_o/valid_o held stable.
//  - Order: output in exact grant order; per source FIFO order preserved.
//  - flush_i=1: count<=0 next edge, src_yumi_o=0 that cycle, rr holds; dequeue that
//    cycle is discarded (downstream must ignore). Flush dominates grant/dequeue.
//  - Reset mid-operation: buffered entries lost, no yumi issued after reset assertion.
// TESTING
//  1 Reset: reset_n_i=0 with src_valid_i=2'b11 -> src_yumi_o=0, valid_o=0; release ->
//    first grant to src0 (rr=0).
//  2 Fairness: N=2, both valid, ready_i=1 constant, src0 data 0x10,0x11.., src1 0x20..
//    -> output 0x10,0x20,0x11,0x21 with src_o 0,1,0,1, one per cycle after 1-cycle fill.
//  3 Backpressure: ready_i=0, both valid -> exactly 2 yumis, then src_yumi_o=0,
//    valid_o=1 and data_o stable for 10 cycles; ready_i=1 -> drains in order, regrants.
//  4 Wrap: N=3, only src2 valid -> grant 2, rr wraps to 0; next only src0,src2 valid ->
//    grant 0 before 2.
//  5 Flush: count=2, flush_i=1 with src0 valid -> no yumi, next cycle valid_o=0, rr same.
//  6 Protocol check (assertions, random stimulus): onehot0(src_yumi_o); yumi=>valid;
//    no loss/duplication versus scoreboard of upstream fifo_synch_1r1w instances.

Source files
------------

// File: rtl/fifo_drain_arb.sv
// Round-robin drain of several valid-yumi FIFO heads into a 2-entry skid buffer.
// The buffer is presented downstream as valid-ready, tagged with the source index.
module fifo_drain_arb #(
  parameter type         DTYPE           = logic [7:0],
  parameter int unsigned num_src_p       = 2,
  parameter int unsigned src_idx_width_p = $clog2(num_src_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic [num_src_p-1:0]       src_valid_i,
  input  DTYPE                       src_data_i [num_src_p],
  output logic [num_src_p-1:0]       src_yumi_o,
  output logic                       valid_o,
  output DTYPE                       data_o,
  output logic [src_idx_width_p-1:0] src_o,
  input  logic                       ready_i
);

  typedef logic [src_idx_width_p-1:0] idx_t;
  typedef logic [src_idx_width_p:0]   idx_ext_t;

  localparam idx_ext_t NUM  = idx_ext_t'(num_src_p);
  localparam idx_t     LAST = idx_t'(num_src_p - 1);

  DTYPE       buf_data [2];
  idx_t       buf_src  [2];
  logic       head;
  logic [1:0] count;
  idx_t       rr;

  logic       grant;
  idx_t       grant_idx;
  idx_ext_t   scan_sum;
  idx_t       scan_idx;
  logic       deq;
  logic       tail;

  // Full buffer never grants, so yumi never depends on ready_i.
  always_comb begin
    grant      = 1'b0;
    grant_idx  = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    src_yumi_o = '0;
    if (reset_n_i && !flush_i && count != 2'd2) begin
      for (int unsigned k = 0; k < num_src_p; k++) begin
        scan_sum = {1'b0, rr} + idx_ext_t'(k);
        if (scan_sum >= NUM) scan_sum = scan_sum - NUM;
        scan_idx = scan_sum[src_idx_width_p-1:0];
        if (!grant && src_valid_i[scan_idx]) begin
          grant     = 1'b1;
          grant_idx = scan_idx;
        end
      end
      if (grant) src_yumi_o[grant_idx] = 1'b1;
    end
  end

  assign valid_o = (count != 2'd0);
  assign data_o  = buf_data[head];
  assign src_o   = buf_src[head];
  assign deq     = valid_o & ready_i;
  assign tail    = head ^ count[0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
      head  <= 1'b0;
      rr    <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else begin
      if (grant) rr <= (grant_idx == LAST) ? '0 : grant_idx + idx_t'(1);
      if (deq) head <= ~head;
      count <= count + {1'b0, grant} - {1'b0, deq};
    end
  end

  // Payload storage needs no reset: it is only observed while count != 0.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      buf_data[tail] <= src_data_i[grant_idx];
      buf_src[tail]  <= grant_idx;
    end
  end

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Directed and randomised checks of fifo_drain_arb with 2 and 3 sources.
// Sources are modelled as counters whose value advances on each yumi.
module tb_fifo_drain_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       src_rst;
  logic [1:0] valid2;
  logic [7:0] sdata2 [2];
  logic [1:0] yumi2;
  logic       vout2;
  logic [7:0] dout2;
  logic       sout2;
  logic       ready2;
  logic [7:0] cnt0, cnt1;

  logic [2:0] valid3;
  logic [7:0] sdata3 [3];
  logic [2:0] yumi3;
  logic       vout3;
  logic [7:0] dout3;
  logic [1:0] sout3;
  logic       ready3;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb [$];
  logic [8:0] exp_item;

  always #5 clk = ~clk;

  fifo_drain_arb #(.num_src_p(2)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .src_valid_i(valid2), .src_data_i(sdata2), .src_yumi_o(yumi2),
    .valid_o(vout2), .data_o(dout2), .src_o(sout2), .ready_i(ready2)
  );

  fifo_drain_arb #(.num_src_p(3)) dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(1'b0),
    .src_valid_i(valid3), .src_data_i(sdata3), .src_yumi_o(yumi3),
    .valid_o(vout3), .data_o(dout3), .src_o(sout3), .ready_i(ready3)
  );

  assign sdata2[0] = 8'h10 + cnt0;
  assign sdata2[1] = 8'h20 + cnt1;
  assign sdata3[0] = 8'hA0;
  assign sdata3[1] = 8'hA1;
  assign sdata3[2] = 8'hA2;

  always @(posedge clk) begin
    if (src_rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (yumi2[0]) cnt0 <= cnt0 + 8'd1;
      if (yumi2[1]) cnt1 <= cnt1 + 8'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] v2, input logic r2);
    reset_n = 1'b0;
    src_rst = 1'b1;
    flush   = 1'b0;
    valid2  = v2;
    ready2  = r2;
    tick();
    reset_n = 1'b1;
    src_rst = 1'b0;
    #1;
  endtask

  initial begin
    reset_n = 1'b1; src_rst = 1'b0; flush = 1'b0;
    valid2 = '0; ready2 = 1'b0; valid3 = '0; ready3 = 1'b0;
    #2;

    // Reset holds off yumi even with both sources valid
    reset_n = 1'b0; src_rst = 1'b1; valid2 = 2'b11; ready2 = 1'b1;
    #1;
    chk("rst_yumi", 32'(yumi2), 32'h0);
    chk("rst_valid", 32'(vout2), 32'h0);
    chk("rst_valid3", 32'(vout3), 32'h0);
    tick();
    reset_n = 1'b1; src_rst = 1'b0;
    #1;
    chk("first_grant", 32'(yumi2), 32'h1);

    // Fairness: alternate sources, one item per cycle
    tick(); chk("fair0_d", 32'(dout2), 32'h10); chk("fair0_s", 32'(sout2), 32'h0);
            chk("fair0_yumi", 32'(yumi2), 32'h2);
    tick(); chk("fair1_d", 32'(dout2), 32'h20); chk("fair1_s", 32'(sout2), 32'h1);
    tick(); chk("fair2_d", 32'(dout2), 32'h11); chk("fair2_s", 32'(sout2), 32'h0);
    tick(); chk("fair3_d", 32'(dout2), 32'h21); chk("fair3_s", 32'(sout2), 32'h1);
            chk("fair3_v", 32'(vout2), 32'h1);

    // Backpressure: two grants then stall
    do_reset(2'b11, 1'b0);
    chk("bp_y0", 32'(yumi2), 32'h1);
    tick(); chk("bp_y1", 32'(yumi2), 32'h2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_y", 32'(yumi2), 32'h0);
      chk("bp_hold_v", 32'(vout2), 32'h1);
      chk("bp_hold_d", 32'(dout2), 32'h10);
      chk("bp_hold_s", 32'(sout2), 32'h0);
    end
    ready2 = 1'b1;
    #1;
    chk("bp_full_ready_y", 32'(yumi2), 32'h0);
    tick(); chk("bp_drain0_d", 32'(dout2), 32'h20); chk("bp_drain0_s", 32'(sout2), 32'h1);
            chk("bp_regrant", 32'(yumi2), 32'h1);
    tick(); chk("bp_drain1_d", 32'(dout2), 32'h11); chk("bp_drain1_s", 32'(sout2), 32'h0);

    // Flush with full buffer: rr stays at 0
    do_reset(2'b11, 1'b0);
    tick(); tick();
    valid2 = 2'b01; flush = 1'b1;
    #1;
    chk("fl_full_y", 32'(yumi2), 32'h0);
    tick();
    flush = 1'b0; valid2 = 2'b11;
    #1;
    chk("fl_full_v", 32'(vout2), 32'h0);
    chk("fl_full_rr", 32'(yumi2), 32'h1);

    // Flush with one entry: flush gates the grant, rr stays at 1
    do_reset(2'b11, 1'b0);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_one_y", 32'(yumi2), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_one_v", 32'(vout2), 32'h0);
    chk("fl_one_rr", 32'(yumi2), 32'h2);

    // Wrap with three sources
    valid2 = '0;
    ready3 = 1'b1;
    valid3 = 3'b100;
    #1;
    chk("wr_y2", 32'(yumi3), 32'h4);
    tick();
    valid3 = 3'b101;
    #1;
    chk("wr_out2_s", 32'(sout3), 32'h2);
    chk("wr_out2_d", 32'(dout3), 32'hA2);
    chk("wr_y0", 32'(yumi3), 32'h1);
    tick();
    chk("wr_out0_s", 32'(sout3), 32'h0);
    chk("wr_out0_d", 32'(dout3), 32'hA0);
    chk("wr_y_after0", 32'(yumi3), 32'h4);
    valid3 = '0;

    // Random traffic against a grant-order scoreboard
    do_reset(2'b00, 1'b0);
    sb.delete();
    for (int c = 0; c < 400; c++) begin
      valid2 = (c < 360) ? 2'($urandom_range(0, 3)) : 2'b00;
      ready2 = (c < 360) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      chk("rnd_onehot", 32'($onehot0(yumi2)), 32'h1);
      chk("rnd_yumi_valid", 32'(yumi2 & ~valid2), 32'h0);
      if (vout2 && ready2) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious", 32'(vout2), 32'h0);
        end else begin
          exp_item = sb.pop_front();
          chk("rnd_data", 32'({sout2, dout2}), 32'(exp_item));
        end
      end
      if (yumi2[0]) sb.push_back({1'b0, sdata2[0]});
      if (yumi2[1]) sb.push_back({1'b1, sdata2[1]});
      tick();
    end
    chk("rnd_sb_empty", 32'(sb.size()), 32'h0);
    chk("rnd_final_v", 32'(vout2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
